// File: rtl/m_stage_pkg.sv
// Shared constants for the memory stage: memory opcodes, exception codes, DM depth.
package m_stage_pkg;

   localparam int unsigned DM_WORDS_DEF = 4096;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_OV   = 5'd12;

   function automatic logic is_load(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/m_stage_ld.sv
// Load extender: selects the addressed byte/halfword of a DM word and extends it.
module ld_ext
   import m_stage_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [5:0]  op,
   output logic [31:0] dm_rd
);

   logic [15:0] half;
   logic [7:0]  byte_sel;

   always_comb begin
      half     = addr_lo[1] ? word[31:16] : word[15:0];
      byte_sel = word[8*addr_lo +: 8];
      dm_rd    = '0;
      case (op)
         OP_LW:   dm_rd = word;
         OP_LH:   dm_rd = {{16{half[15]}}, half};
         OP_LHU:  dm_rd = {16'h0000, half};
         OP_LB:   dm_rd = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  dm_rd = {24'h000000, byte_sel};
         default: dm_rd = '0;
      endcase
   end

endmodule

// File: rtl/m_stage.sv
// MIPS memory stage: E/M pipeline register, address/overflow exception check,
// byte-lane data memory with store-data forwarding and combinational load path.
module m_stage
   import m_stage_pkg::*;
#(
   parameter int unsigned DM_WORDS = DM_WORDS_DEF
)(
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_E,
   input  logic [31:0] pc4_E,
   input  logic [31:0] AO,
   input  logic [31:0] MFRTEOUT,
   input  logic        over,
   input  logic        IntReq,
   input  logic [31:0] MUX_WDOUT,
   input  logic        FRTM,
   output logic [31:0] IR_M,
   output logic [31:0] pc4_M,
   output logic [31:0] AO_M,
   output logic [31:0] DM_RD,
   output logic [4:0]  exc_M,
   output logic        exc_vld_M
);

   localparam int unsigned AW = $clog2(DM_WORDS);
   localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

   logic [31:0] RT_M;
   logic        OV_M;
   logic [31:0] mem [DM_WORDS];

   logic [5:0]    op;
   logic          ld, st, misal, oor;
   logic [31:0]   sd, wd;
   logic [3:0]    be;
   logic          we;
   logic [AW-1:0] idx;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         IR_M  <= '0;
         pc4_M <= '0;
         AO_M  <= '0;
         RT_M  <= '0;
         OV_M  <= 1'b0;
      end else if (IntReq) begin
         IR_M  <= '0;
         pc4_M <= '0;
         AO_M  <= '0;
         RT_M  <= '0;
         OV_M  <= 1'b0;
      end else begin
         IR_M  <= IR_E;
         pc4_M <= pc4_E;
         AO_M  <= AO;
         RT_M  <= MFRTEOUT;
         OV_M  <= over;
      end
   end

   assign op  = IR_M[31:26];
   assign ld  = is_load(op);
   assign st  = is_store(op);
   assign idx = AO_M[AW+1:2];
   assign sd  = FRTM ? MUX_WDOUT : RT_M;

   always_comb begin
      misal = 1'b0;
      if ((op == OP_LW) || (op == OP_SW))
         misal = (AO_M[1:0] != 2'b00);
      else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
         misal = AO_M[0];
      oor = (AO_M >= DM_BYTES);

      exc_M = EXC_NONE;
      if (ld || st) begin
         if (OV_M || misal || oor)
            exc_M = ld ? EXC_ADEL : EXC_ADES;
      end else if (OV_M) begin
         exc_M = EXC_OV;
      end
   end

   assign exc_vld_M = (exc_M != EXC_NONE);
   assign we        = st && !exc_vld_M && !IntReq;

   // Replicate the store data onto every lane; the byte enables pick the lanes.
   always_comb begin
      wd = sd;
      be = 4'b0000;
      case (op)
         OP_SW: be = 4'b1111;
         OP_SH: begin
            wd = {sd[15:0], sd[15:0]};
            be = AO_M[1] ? 4'b1100 : 4'b0011;
         end
         OP_SB: begin
            wd = {4{sd[7:0]}};
            be = 4'b0001 << AO_M[1:0];
         end
         default: be = 4'b0000;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         for (int unsigned i = 0; i < DM_WORDS; i++)
            mem[i] <= '0;
      end else if (we) begin
         for (int unsigned l = 0; l < 4; l++)
            if (be[l])
               mem[idx][8*l +: 8] <= wd[8*l +: 8];
      end
   end

   ld_ext u_ld_ext (
      .word    (mem[idx]),
      .addr_lo (AO_M[1:0]),
      .op      (op),
      .dm_rd   (DM_RD)
   );

endmodule

// File: tb/tb_m_stage.sv
// Directed self-checking bench for m_stage: loads/stores, exceptions, forwarding, interrupt and reset.
module tb_m_stage;
   import m_stage_pkg::*;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_E, pc4_E, AO, MFRTEOUT, MUX_WDOUT;
   logic        over, IntReq, FRTM;
   logic [31:0] IR_M, pc4_M, AO_M, DM_RD;
   logic [4:0]  exc_M;
   logic        exc_vld_M;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always #5 clk = ~clk;

   m_stage #(.DM_WORDS(4096)) dut (
      .clk       (clk),
      .clr       (clr),
      .IR_E      (IR_E),
      .pc4_E     (pc4_E),
      .AO        (AO),
      .MFRTEOUT  (MFRTEOUT),
      .over      (over),
      .IntReq    (IntReq),
      .MUX_WDOUT (MUX_WDOUT),
      .FRTM      (FRTM),
      .IR_M      (IR_M),
      .pc4_M     (pc4_M),
      .AO_M      (AO_M),
      .DM_RD     (DM_RD),
      .exc_M     (exc_M),
      .exc_vld_M (exc_vld_M)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one instruction at E, then step to its M cycle (sampled 1 ns after the edge).
   task automatic issue(input logic [5:0] opc, input logic [31:0] addr,
                        input logic [31:0] rt, input logic ov);
      IR_E     = {opc, 26'h0000123};
      pc4_E    = 32'h0040_0000 + addr;
      AO       = addr;
      MFRTEOUT = rt;
      over     = ov;
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b0; IR_E = '0; pc4_E = '0; AO = '0; MFRTEOUT = '0;
      MUX_WDOUT = '0; over = 1'b0; IntReq = 1'b0; FRTM = 1'b0;
      #12;
      check("rst_ir",  IR_M, 32'h0);
      check("rst_exc", {27'h0, exc_M}, 32'h0);
      check("rst_rd",  DM_RD, 32'h0);
      @(negedge clk);
      clr = 1'b1;

      // sw then lw
      issue(OP_SW, 32'h10, 32'h1234_5678, 1'b0);
      check("sw_vld", {31'h0, exc_vld_M}, 32'h0);
      check("sw_pc4", pc4_M, 32'h0040_0010);
      issue(OP_LW, 32'h10, 32'h0, 1'b0);
      check("lw_rd",  DM_RD, 32'h1234_5678);
      check("lw_vld", {31'h0, exc_vld_M}, 32'h0);

      // sb / lb / lbu
      issue(OP_SW,  32'h10, 32'h1122_3344, 1'b0);
      issue(OP_SB,  32'h13, 32'h0000_0080, 1'b0);
      issue(OP_LW,  32'h10, 32'h0, 1'b0);
      check("sb_word", DM_RD, 32'h8022_3344);
      issue(OP_LB,  32'h13, 32'h0, 1'b0);
      check("lb_rd",   DM_RD, 32'hFFFF_FF80);
      issue(OP_LBU, 32'h13, 32'h0, 1'b0);
      check("lbu_rd",  DM_RD, 32'h0000_0080);

      // sh / lh / lhu
      issue(OP_SH,  32'h22, 32'h0000_BEEF, 1'b0);
      issue(OP_LW,  32'h20, 32'h0, 1'b0);
      check("sh_word", DM_RD, 32'hBEEF_0000);
      issue(OP_LH,  32'h22, 32'h0, 1'b0);
      check("lh_rd",   DM_RD, 32'hFFFF_BEEF);
      issue(OP_LHU, 32'h22, 32'h0, 1'b0);
      check("lhu_rd",  DM_RD, 32'h0000_BEEF);

      // exceptions
      issue(OP_SW, 32'h11, 32'hDEAD_BEEF, 1'b0);
      check("sw_mis_exc", {27'h0, exc_M}, 32'd5);
      check("sw_mis_vld", {31'h0, exc_vld_M}, 32'h1);
      issue(OP_LW, 32'h10, 32'h0, 1'b0);
      check("sw_mis_mem", DM_RD, 32'h8022_3344);
      issue(OP_LH, 32'h21, 32'h0, 1'b0);
      check("lh_mis_exc", {27'h0, exc_M}, 32'd4);
      issue(6'b000000, 32'h7FFF_FFFF, 32'h0, 1'b1);
      check("add_ov_exc", {27'h0, exc_M}, 32'd12);
      issue(OP_LW, 32'h10, 32'h0, 1'b1);
      check("lw_ov_exc", {27'h0, exc_M}, 32'd4);
      issue(OP_SW, 32'h4000, 32'hDEAD_BEEF, 1'b0);
      check("sw_oor_exc", {27'h0, exc_M}, 32'd5);
      issue(OP_LW, 32'h0, 32'h0, 1'b0);
      check("sw_oor_mem", DM_RD, 32'h0);
      check("lw0_vld", {31'h0, exc_vld_M}, 32'h0);

      // W-stage forwarding into store data
      issue(OP_SW, 32'h30, 32'h0, 1'b0);
      FRTM = 1'b1; MUX_WDOUT = 32'hCAFE_F00D;
      issue(OP_LW, 32'h30, 32'h0, 1'b0);
      FRTM = 1'b0; MUX_WDOUT = '0;
      check("fwd_rd", DM_RD, 32'hCAFE_F00D);

      // interrupt while a store is in M
      issue(OP_SW, 32'h40, 32'h0000_0055, 1'b0);
      IntReq = 1'b1;
      issue(OP_LW, 32'h40, 32'h0, 1'b0);
      IntReq = 1'b0;
      check("int_ir",  IR_M, 32'h0);
      check("int_vld", {31'h0, exc_vld_M}, 32'h0);
      check("int_rd",  DM_RD, 32'h0);
      issue(OP_LW, 32'h40, 32'h0, 1'b0);
      check("int_nowr", DM_RD, 32'h0);

      // asynchronous clear mid-cycle
      issue(OP_LW, 32'h10, 32'h0, 1'b0);
      check("pre_clr_rd", DM_RD, 32'h8022_3344);
      #2;
      clr = 1'b0;
      #1;
      check("clr_ir",  IR_M,  32'h0);
      check("clr_pc4", pc4_M, 32'h0);
      check("clr_ao",  AO_M,  32'h0);
      check("clr_rd",  DM_RD, 32'h0);
      check("clr_exc", {26'h0, exc_vld_M, exc_M}, 32'h0);
      @(negedge clk);
      clr = 1'b1;
      issue(OP_LW, 32'h10, 32'h0, 1'b0);
      check("clr_mem10", DM_RD, 32'h0);
      issue(OP_LW, 32'h30, 32'h0, 1'b0);
      check("clr_mem30", DM_RD, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
